fwd_hazard_unit: RTL
====================

# fwd_hazard_unit

Parametrised forwarding and hazard unit for the 5-stage integer pipeline. It tracks destination-register information for the EX, MEM and WB slots internally, advancing in lock-step with the pipeline. It produces per-operand bypass selects, the load-use stall/bubble, a whole-pipe freeze for multi-cycle data-memory loads, and branch-flush handling. Two saturating hazard counters are included for performance debug. It sits beside the ID/EX register and drives the EX operand muxes plus the PC / IF/ID / ID/EX enables.

## Interface
- REG_AW, 5, register address width
- NUM_SRC, 2, source operands per instruction
- CNT_W, 16, hazard counter width
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_wr  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- id_rd  in  REG_AW  ID destination register
- id_src  in  NUM_SRC*REG_AW  ID source registers; operand k at [k*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  operand k is actually read
- mem_ready  in  1  data memory has load data this cycle
- flush  in  1  branch redirect resolved in EX
- cnt_clr  in  1  synchronous clear of both counters
- fwd_sel  out  NUM_SRC*2  EX operand k select at [2k +: 2]: 00 regfile, 01 MEM/WB, 10 EX/MEM
- stall_if_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  load bubble into ID/EX
- freeze  out  1  hold every pipeline register
- load_use_cnt  out  CNT_W  load-use stall cycles
- mem_wait_cnt  out  CNT_W  freeze cycles

## Operation
- Slot state for EX, MEM and WB: valid, wr, load, rd. The EX slot also holds src and src_used.
- A slot "writes" when valid & wr & rd != 0. Register 0 never forwards and never stalls.
- freeze = MEM slot valid & load & ~mem_ready.
- load_use = OR over k of (id_valid & id_src_used[k] & EX slot writes & EX load & id_src[k] == EX rd).
- stall_if_id = bubble_ex = load_use & ~flush & ~freeze.
- Slot advance is evaluated in priority order:
  - freeze: no slot changes. flush is ignored; its source holds it until the freeze clears.
  - flush: WB<=MEM, MEM<=EX, EX<=invalid.
  - load_use: WB<=MEM, MEM<=EX, EX<=invalid.
  - otherwise: WB<=MEM, MEM<=EX, EX<=ID fields, with valid = id_valid.
- fwd_sel[k], priority high to low:
  - 10 if ~EX src_used[k] is false, MEM slot writes, MEM is not a load, and EX src[k] == MEM rd.
  - 01 if WB slot writes and EX src[k] == WB rd.
  - 00 otherwise. 00 also applies when the EX slot is invalid.
- fwd_sel never takes the value 11. A MEM-slot load never produces 10, because load_use prevents that case.
- Counters:
  - load_use_cnt increments on cycles with stall_if_id=1.
  - mem_wait_cnt increments on cycles with freeze=1.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment: the counter becomes 0 that cycle.

## Timing
- Reset (async assert, sync release): all slots invalid and counters 0. Hence fwd_sel=0, stall_if_id=0, bubble_ex=0, freeze=0 from assertion onward.
- Reset asserted mid-stall or mid-freeze drops all hazard outputs immediately. No in-flight state survives.
- fwd_sel, stall_if_id, bubble_ex and freeze are combinational from current slot state and ID inputs, with zero latency. Slot state updates on the rising edge.
- Load-use costs exactly 1 stall cycle. The next cycle the load is in MEM, and the consumer gets 01 when the load reaches WB.
- A freeze of N cycles holds all outputs constant for N cycles, then resumes the normal advance.
- A simultaneous flush and load_use produces no stall; EX gets a bubble.

## Structure
- Package fwd_pkg holds:
  - constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - typedef slot_t {valid, wr, load, rd}.
- Sub-module fwd_operand_sel, instantiated NUM_SRC times. Inputs: src, src_used, MEM slot, WB slot. Output: 2-bit select.
- Top level holds the slot registers, the advance priority, the load-use reduction and the counters.

## Test plan
- Back-to-back ALU ops (add x3 then sub x4,x3,x3): while sub is in EX, fwd_sel = 4'b1010, with no stall.
- One instruction between the ALU producer of x5 and its consumer: the consumer operand gets 01. With x0 as destination, the consumer gets 00.
- lw x6, then add x7,x6,x1 immediately: one cycle of stall_if_id=bubble_ex=1, then operand 0 gets 01; load_use_cnt=1.
- lw in MEM with mem_ready low for 3 cycles: freeze=1 for 3 cycles, with slots and fwd_sel unchanged; mem_wait_cnt=3.
- flush together with a load-use condition: stall_if_id=0 and EX slot invalid next cycle. flush during freeze: ignored until freeze drops.
- Counter at 16'hFFFF plus another stall: stays 16'hFFFF. cnt_clr then gives 0. rst_n low mid-freeze: all outputs 0 immediately.

Source files
------------

// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the forwarding / hazard unit of the 5-stage integer
// pipeline.
//   FWD_RF / FWD_WB / FWD_MEM : EX operand mux select encodings
//   slot_t                    : per-stage destination record (valid, wr, load, rd)
//   adv_e                     : how the tracked slots move on the next edge
//   slot_writes()             : true when a slot will really write a register
// -----------------------------------------------------------------------------
package fwd_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from MEM/WB result
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX/MEM result

    // Slot rd field is sized for register files of up to 256 entries; narrower
    // register addresses are zero-extended on entry so compares stay exact.
    localparam int SLOT_RD_W = 8;

    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic                 load;
        logic [SLOT_RD_W-1:0] rd;
    } slot_t;

    typedef enum logic [1:0] {
        ADV_NORMAL,  // shift all slots, EX takes the ID instruction
        ADV_BUBBLE,  // shift all slots, EX becomes invalid
        ADV_HOLD     // nothing moves
    } adv_e;

    // Register 0 is hard-wired, so a write to it is never a real producer.
    function automatic logic slot_writes(input slot_t s);
        return s.valid & s.wr & (s.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// -----------------------------------------------------------------------------
// fwd_operand_sel
// Bypass select for one EX source operand.
//   src_i      : EX operand register address
//   src_used_i : operand is read (already qualified with EX slot valid)
//   mem_slot_i : instruction currently in MEM
//   wb_slot_i  : instruction currently in WB
//   sel_o      : FWD_MEM, FWD_WB or FWD_RF
// -----------------------------------------------------------------------------
module fwd_operand_sel
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic              src_used_i,
    input  slot_t             mem_slot_i,
    input  slot_t             wb_slot_i,
    output logic [1:0]        sel_o
);

    logic [SLOT_RD_W-1:0] src_ext;

    assign src_ext = SLOT_RD_W'(src_i);

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_o = FWD_RF;
        if (src_used_i) begin
            // A load in MEM has no data yet; the load-use stall guarantees the
            // consumer never sits in EX behind it, so it is skipped here.
            if (slot_writes(mem_slot_i) && !mem_slot_i.load && src_ext == mem_slot_i.rd) begin
                sel_o = FWD_MEM;
            end else if (slot_writes(wb_slot_i) && src_ext == wb_slot_i.rd) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Forwarding and hazard control for the 5-stage pipeline. Tracks EX/MEM/WB
// destination slots, drives the EX operand bypass selects, the load-use
// stall/bubble, a whole-pipe freeze while a load waits on data memory, and
// two saturating debug counters.
//   clk, rst_n        : clock, async active-low reset
//   id_valid/id_wr/id_is_load/id_rd/id_src/id_src_used : ID-stage instruction
//   mem_ready         : data memory returns load data this cycle
//   flush             : branch redirect resolved in EX
//   cnt_clr           : synchronous clear of both counters
//   fwd_sel           : per-operand bypass select, operand k at [2k +: 2]
//   stall_if_id       : hold PC and IF/ID
//   bubble_ex         : insert bubble into ID/EX
//   freeze            : hold every pipeline register
//   load_use_cnt      : cycles spent in load-use stall
//   mem_wait_cnt      : cycles spent frozen
// -----------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic                      id_wr,
    input  logic                      id_is_load,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      mem_ready,
    input  logic                      flush,
    input  logic                      cnt_clr,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall_if_id,
    output logic                      bubble_ex,
    output logic                      freeze,
    output logic [CNT_W-1:0]          load_use_cnt,
    output logic [CNT_W-1:0]          mem_wait_cnt
);

    slot_t                     ex_q, ex_d;
    slot_t                     mem_q, mem_d;
    slot_t                     wb_q, wb_d;
    logic [NUM_SRC*REG_AW-1:0] ex_src_q, ex_src_d;
    logic [NUM_SRC-1:0]        ex_src_used_q, ex_src_used_d;
    logic [CNT_W-1:0]          lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0]          mw_cnt_q, mw_cnt_d;

    logic load_use;
    logic stall;
    adv_e adv;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign freeze = mem_q.valid & mem_q.load & ~mem_ready;

    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_valid && id_src_used[k] && slot_writes(ex_q) && ex_q.load &&
                SLOT_RD_W'(id_src[k*REG_AW +: REG_AW]) == ex_q.rd) begin
                load_use = 1'b1;
            end
        end
    end

    // A flush squashes the consumer anyway, and a freeze already holds the
    // front end, so neither needs a separate stall.
    assign stall       = load_use & ~flush & ~freeze;
    assign stall_if_id = stall;
    assign bubble_ex   = stall;

    // ------------------------------------------------------------------
    // Operand bypass selects
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_opsel
        fwd_operand_sel #(
            .REG_AW (REG_AW)
        ) u_opsel (
            .src_i      (ex_src_q[k*REG_AW +: REG_AW]),
            .src_used_i (ex_src_used_q[k] & ex_q.valid),
            .mem_slot_i (mem_q),
            .wb_slot_i  (wb_q),
            .sel_o      (fwd_sel[2*k +: 2])
        );
    end

    // ------------------------------------------------------------------
    // Slot advance
    // ------------------------------------------------------------------
    // Freeze wins over flush: the branch unit keeps flush asserted until the
    // freeze clears, so nothing is lost by ignoring it here.
    always_comb begin
        adv = ADV_NORMAL;
        if (freeze) begin
            adv = ADV_HOLD;
        end else if (flush || load_use) begin
            adv = ADV_BUBBLE;
        end
    end

    always_comb begin
        ex_d          = ex_q;
        mem_d         = mem_q;
        wb_d          = wb_q;
        ex_src_d      = ex_src_q;
        ex_src_used_d = ex_src_used_q;
        case (adv)
            ADV_BUBBLE: begin
                wb_d          = mem_q;
                mem_d         = ex_q;
                ex_d          = '0;
                ex_src_used_d = '0;
            end
            ADV_NORMAL: begin
                wb_d          = mem_q;
                mem_d         = ex_q;
                ex_d.valid    = id_valid;
                ex_d.wr       = id_wr;
                ex_d.load     = id_is_load;
                ex_d.rd       = SLOT_RD_W'(id_rd);
                ex_src_d      = id_src;
                ex_src_used_d = id_src_used;
            end
            default: ;  // ADV_HOLD: keep everything
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating debug counters; clear beats increment
    // ------------------------------------------------------------------
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        mw_cnt_d = mw_cnt_q;
        if (cnt_clr) begin
            lu_cnt_d = '0;
            mw_cnt_d = '0;
        end else begin
            if (stall && lu_cnt_q != {CNT_W{1'b1}}) lu_cnt_d = lu_cnt_q + CNT_W'(1);
            if (freeze && mw_cnt_q != {CNT_W{1'b1}}) mw_cnt_d = mw_cnt_q + CNT_W'(1);
        end
    end

    assign load_use_cnt = lu_cnt_q;
    assign mem_wait_cnt = mw_cnt_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge next-state value regardless of statement order.
    // NOTE: every slot is reset, not just valid; the hazard outputs are
    // combinational from these flops, so they drop the moment rst_n asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            ex_src_q      <= '0;
            ex_src_used_q <= '0;
            lu_cnt_q      <= '0;
            mw_cnt_q      <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            ex_src_q      <= ex_src_d;
            ex_src_used_q <= ex_src_used_d;
            lu_cnt_q      <= lu_cnt_d;
            mw_cnt_q      <= mw_cnt_d;
        end
    end

endmodule
